crc_frame_engine: RTL and testbench
===================================

CRC_FRAME_ENGINE -- requirements
Module: crc_frame_engine

Interface
REQ-001 Parameter CRC_WIDTH, default 8, CRC register width (1..32).
REQ-002 Parameter DATA_WIDTH, default 8, data beat width (1..64).
REQ-003 Parameter POLY, default 8'h07, generator polynomial, implicit top bit omitted, CRC_WIDTH bits.
REQ-004 Parameter INIT, default 0, CRC register value loaded at frame start, CRC_WIDTH bits.
REQ-005 Parameter REF_IN, default 0, 1 = bit-reverse each data beat before processing.
REQ-006 Parameter REF_OUT, default 0, 1 = bit-reverse the final CRC before XOR_OUT.
REQ-007 Parameter XOR_OUT, default 0, value XORed into the final CRC, CRC_WIDTH bits.
REQ-008 Parameter CNT_WIDTH, default 16, beat counter width.
REQ-009 clk  input  1  sole clock; all state updates on rising edge.
REQ-010 rst_n  input  1  synchronous, active-high reset (asserted = 1, sampled on rising clk).
REQ-011 s_valid  input  1  input beat valid.
REQ-012 s_ready  output  1  engine can accept a beat.
REQ-013 s_data  input  DATA_WIDTH  input beat, MSB processed first (after optional reflection).
REQ-014 s_sop  input  1  beat is first of frame.
REQ-015 s_last  input  1  beat is last of frame.
REQ-016 m_valid  output  1  final CRC available.
REQ-017 m_ready  input  1  downstream accepts result.
REQ-018 m_crc  output  CRC_WIDTH  final CRC of frame.
REQ-019 m_beats  output  CNT_WIDTH  accepted beats in frame, saturating.
REQ-020 err_pulse  output  1  one-cycle protocol-error flag.

Function
REQ-021 Beat accepted iff s_valid && s_ready on a rising edge.
REQ-022 FSM states IDLE, ACCUM, DONE; reset state IDLE.
REQ-023 s_ready = 1 in IDLE and ACCUM, 0 in DONE.
REQ-024 IDLE: accepted beat with s_sop=1 -> crc = step(INIT, beat), beats = 1; next ACCUM, or DONE if s_last=1.
REQ-025 IDLE: accepted beat with s_sop=0 -> beat discarded, err_pulse = 1 next cycle, stay IDLE.
REQ-026 ACCUM: accepted beat with s_sop=0 -> crc = step(crc, beat), beats += 1 (saturate at all-ones); next DONE if s_last=1.
REQ-027 ACCUM: accepted beat with s_sop=1 -> frame restarts as in REQ-024, err_pulse = 1 next cycle.
REQ-028 step() = DATA_WIDTH serial LFSR iterations in one cycle: fb = crc[MSB] ^ data bit; crc = (crc << 1) ^ (fb ? POLY : 0).
REQ-029 DONE: m_valid = 1; m_crc = (REF_OUT ? reverse(crc) : crc) ^ XOR_OUT; m_beats stable; all outputs held until m_valid && m_ready.
REQ-030 DONE with m_ready = 1 -> next IDLE; result latency = 1 cycle after last beat accepted; throughput one frame per (beats + 1) cycles minimum.
REQ-031 s_valid while in DONE is ignored (not accepted, no error).
REQ-032 m_valid, err_pulse only registered outputs; no combinational path from s_* to m_*.
REQ-033 Outside DONE, m_crc and m_beats = 0.

Reset
REQ-034 rst_n = 1 at a clock edge -> state IDLE, crc = INIT, beats = 0, m_valid = 0, m_crc = 0, m_beats = 0, err_pulse = 0, s_ready = 1 on the following cycle.
REQ-035 Reset mid-frame or in DONE aborts the frame; no result is produced for it.
REQ-036 Reset has priority over any simultaneous beat or m_ready.

Verification
REQ-037 Defaults, single beat 0x31 sop+last -> one cycle later m_valid=1, m_crc=0x97, m_beats=1.
REQ-038 Defaults, frame "123456789" (9 beats, sop on first, last on ninth) -> m_crc=0xF4, m_beats=9.
REQ-039 CRC_WIDTH=16, POLY=16'h1021, INIT=16'hFFFF, "123456789" -> m_crc=0x29B1; with REF_IN=REF_OUT=1, POLY=16'h8005, INIT=0 -> 0xBB3D.
REQ-040 Backpressure: m_ready=0 for 5 cycles in DONE with s_valid=1 -> m_crc/m_beats stable, s_ready=0, no beat consumed; m_ready=1 -> IDLE next cycle.
REQ-041 Protocol errors: beat without sop in IDLE -> err_pulse one cycle, no m_valid; sop mid-frame -> err_pulse, CRC restarts, final matches restarted frame only.
REQ-042 rst_n=1 for one cycle after 4 beats of a frame -> outputs zero, s_ready=1; next full frame yields correct CRC from INIT.

Source files
------------

// File: rtl/crc_frame_engine.sv
// Framed CRC engine: folds each accepted data beat into a CRC register one beat
// per cycle and presents the finished CRC plus beat count until downstream takes it.
module crc_frame_engine #(
   parameter int                   CRC_WIDTH  = 8,
   parameter int                   DATA_WIDTH = 8,
   parameter logic [CRC_WIDTH-1:0] POLY       = 8'h07,
   parameter logic [CRC_WIDTH-1:0] INIT       = '0,
   parameter bit                   REF_IN     = 1'b0,
   parameter bit                   REF_OUT    = 1'b0,
   parameter logic [CRC_WIDTH-1:0] XOR_OUT    = '0,
   parameter int                   CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_sop,
   input  logic                  s_last,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [CRC_WIDTH-1:0]  m_crc,
   output logic [CNT_WIDTH-1:0]  m_beats,
   output logic                  err_pulse
);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t                 state_q, state_d;
   logic [CRC_WIDTH-1:0]   crc_q, crc_d;
   logic [CNT_WIDTH-1:0]   beats_q, beats_d;
   logic                   err_q, err_d;
   logic                   accept;
   logic [CRC_WIDTH-1:0]   crc_rev;

   // Unrolled bit-serial LFSR: the whole beat is folded in within one cycle.
   function automatic logic [CRC_WIDTH-1:0] crc_step(input logic [CRC_WIDTH-1:0] c_in,
                                                     input logic [DATA_WIDTH-1:0] d);
      logic [CRC_WIDTH-1:0]  c;
      logic [DATA_WIDTH-1:0] dd;
      for (int i = 0; i < DATA_WIDTH; i++)
         dd[i] = REF_IN ? d[DATA_WIDTH-1-i] : d[i];
      c = c_in;
      for (int i = DATA_WIDTH-1; i >= 0; i--)
         c = (c << 1) ^ ((c[CRC_WIDTH-1] ^ dd[i]) ? POLY : '0);
      return c;
   endfunction

   assign s_ready = (state_q != DONE);
   assign accept  = s_valid && s_ready;

   always_comb begin
      state_d = state_q;
      crc_d   = crc_q;
      beats_d = beats_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (s_sop) begin
                  crc_d   = crc_step(INIT, s_data);
                  beats_d = CNT_WIDTH'(1);
                  state_d = s_last ? DONE : ACCUM;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ACCUM: begin
            if (accept) begin
               // A fresh sop mid-frame abandons the partial frame and restarts.
               if (s_sop) begin
                  crc_d   = crc_step(INIT, s_data);
                  beats_d = CNT_WIDTH'(1);
                  err_d   = 1'b1;
               end else begin
                  crc_d = crc_step(crc_q, s_data);
                  if (beats_q != '1)
                     beats_d = beats_q + CNT_WIDTH'(1);
               end
               state_d = s_last ? DONE : ACCUM;
            end
         end
         DONE: begin
            if (m_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q <= IDLE;
         crc_q   <= INIT;
         beats_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         crc_q   <= crc_d;
         beats_q <= beats_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      crc_rev = '0;
      for (int i = 0; i < CRC_WIDTH; i++)
         crc_rev[CRC_WIDTH-1-i] = crc_q[i];
   end

   // Outputs derive only from registered state, so nothing on s_* reaches m_*.
   assign m_valid   = (state_q == DONE);
   assign m_crc     = m_valid ? ((REF_OUT ? crc_rev : crc_q) ^ XOR_OUT) : '0;
   assign m_beats   = m_valid ? beats_q : '0;
   assign err_pulse = err_q;

endmodule

// File: tb/tb_crc_frame_engine.sv
// Bench for crc_frame_engine: three configurations driven in lockstep against a
// frame-level reference model, plus literal check values for known CRCs.
module tb_crc_frame_engine;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       s_valid = 1'b0, s_sop = 1'b0, s_last = 1'b0, m_ready = 1'b0;
   logic [7:0] s_data = '0;

   logic        d0_rdy, d0_mv, d0_err;
   logic [7:0]  d0_crc;
   logic [15:0] d0_beats;
   logic        d1_rdy, d1_mv, d1_err;
   logic [15:0] d1_crc;
   logic [15:0] d1_beats;
   logic        d2_rdy, d2_mv, d2_err;
   logic [15:0] d2_crc;
   logic [2:0]  d2_beats;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   crc_frame_engine u_d0 (
      .clk(clk), .rst_n(rst), .s_valid(s_valid), .s_ready(d0_rdy), .s_data(s_data),
      .s_sop(s_sop), .s_last(s_last), .m_valid(d0_mv), .m_ready(m_ready),
      .m_crc(d0_crc), .m_beats(d0_beats), .err_pulse(d0_err));

   crc_frame_engine #(.CRC_WIDTH(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOR_OUT(16'h0000)) u_d1 (
      .clk(clk), .rst_n(rst), .s_valid(s_valid), .s_ready(d1_rdy), .s_data(s_data),
      .s_sop(s_sop), .s_last(s_last), .m_valid(d1_mv), .m_ready(m_ready),
      .m_crc(d1_crc), .m_beats(d1_beats), .err_pulse(d1_err));

   crc_frame_engine #(.CRC_WIDTH(16), .POLY(16'h8005), .INIT(16'h0000), .REF_IN(1'b1),
                      .REF_OUT(1'b1), .XOR_OUT(16'h0000), .CNT_WIDTH(3)) u_d2 (
      .clk(clk), .rst_n(rst), .s_valid(s_valid), .s_ready(d2_rdy), .s_data(s_data),
      .s_sop(s_sop), .s_last(s_last), .m_valid(d2_mv), .m_ready(m_ready),
      .m_crc(d2_crc), .m_beats(d2_beats), .err_pulse(d2_err));

   // Reference model: frame bytes collected in a queue, result computed from the whole message.
   byte unsigned q[$];
   bit  pend = 0, in_frame = 0, e_err = 0, mv = 0;

   function automatic logic [31:0] crc_ref(input int w, input logic [31:0] poly, input logic [31:0] init,
                                           input bit rin, input bit rout);
      logic [31:0] c, r, mask;
      logic [7:0]  b, br;
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
      c = init;
      foreach (q[i]) begin
         b = q[i];
         for (int k = 0; k < 8; k++) br[7-k] = b[k];
         if (rin) b = br;
         for (int k = 7; k >= 0; k--)
            c = (c[w-1] ^ b[k]) ? (((c << 1) ^ poly) & mask) : ((c << 1) & mask);
      end
      if (rout) begin
         r = '0;
         for (int k = 0; k < w; k++) r[w-1-k] = c[k];
         c = r;
      end
      return c;
   endfunction

   function automatic int sat(input int n, input int cw);
      int lim;
      lim = (1 << cw) - 1;
      return (n > lim) ? lim : n;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         pend = 0; in_frame = 0; e_err = 0; q.delete(); mv = 1;
      end else begin
         e_err = 0;
         if (pend) begin
            if (m_ready) pend = 0;
         end else if (s_valid) begin
            if (s_sop) begin
               e_err = in_frame;
               q.delete();
               q.push_back(s_data);
               in_frame = 1;
            end else if (in_frame) begin
               q.push_back(s_data);
            end else begin
               e_err = 1;
            end
            if (in_frame && s_last) begin
               pend = 1; in_frame = 0;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (mv) begin
         chk("d0 s_ready", 32'(d0_rdy), 32'(!pend));
         chk("d0 m_valid", 32'(d0_mv), 32'(pend));
         chk("d0 err", 32'(d0_err), 32'(e_err));
         chk("d0 m_crc", 32'(d0_crc), pend ? crc_ref(8, 32'h07, 32'h0, 0, 0) : 32'h0);
         chk("d0 m_beats", 32'(d0_beats), pend ? 32'(sat(q.size(), 16)) : 32'h0);
         chk("d1 s_ready", 32'(d1_rdy), 32'(!pend));
         chk("d1 m_valid", 32'(d1_mv), 32'(pend));
         chk("d1 err", 32'(d1_err), 32'(e_err));
         chk("d1 m_crc", 32'(d1_crc), pend ? crc_ref(16, 32'h1021, 32'hFFFF, 0, 0) : 32'h0);
         chk("d1 m_beats", 32'(d1_beats), pend ? 32'(sat(q.size(), 16)) : 32'h0);
         chk("d2 s_ready", 32'(d2_rdy), 32'(!pend));
         chk("d2 m_valid", 32'(d2_mv), 32'(pend));
         chk("d2 err", 32'(d2_err), 32'(e_err));
         chk("d2 m_crc", 32'(d2_crc), pend ? crc_ref(16, 32'h8005, 32'h0, 1, 1) : 32'h0);
         chk("d2 m_beats", 32'(d2_beats), pend ? 32'(sat(q.size(), 3)) : 32'h0);
      end
   end

   // Apply one cycle of inputs, hold them across the next rising edge.
   task automatic cyc(input logic v, input logic [7:0] d, input logic sop, input logic last,
                      input logic mr, input logic r);
      s_valid = v; s_data = d; s_sop = sop; s_last = last; m_ready = mr; rst = r;
      @(posedge clk); #1;
   endtask

   task automatic frame_123(input logic mr_last);
      string s;
      s = "123456789";
      for (int i = 0; i < 9; i++)
         cyc(1'b1, s[i], i == 0, i == 8, (i == 8) ? mr_last : 1'b0, 1'b0);
   endtask

   initial begin
      cyc(0, 8'h00, 0, 0, 0, 1);
      cyc(0, 8'h00, 0, 0, 0, 1);
      cyc(0, 8'h00, 0, 0, 0, 0);

      // Single-beat frame: result the cycle after acceptance.
      cyc(1, 8'h31, 1, 1, 0, 0);
      s_valid = 0; m_ready = 0;
      @(negedge clk);
      chk("lit 0x31 crc", 32'(d0_crc), 32'h97);
      chk("lit 0x31 beats", 32'(d0_beats), 32'd1);
      chk("lit 0x31 valid", 32'(d0_mv), 32'd1);
      @(posedge clk); #1;
      cyc(0, 8'h00, 0, 0, 1, 0);

      // Check string under backpressure with incoming beats that must be ignored.
      frame_123(1'b0);
      for (int k = 0; k < 5; k++) begin
         s_valid = 1; s_sop = 1; s_last = 1; s_data = 8'($urandom); m_ready = 0;
         @(negedge clk);
         chk("lit crc8", 32'(d0_crc), 32'hF4);
         chk("lit beats9", 32'(d0_beats), 32'd9);
         chk("lit ccitt", 32'(d1_crc), 32'h29B1);
         chk("lit arc", 32'(d2_crc), 32'hBB3D);
         chk("lit sat beats", 32'(d2_beats), 32'd7);
         chk("lit bp s_ready", 32'(d0_rdy), 32'd0);
         @(posedge clk); #1;
      end
      cyc(0, 8'h00, 0, 0, 1, 0);
      cyc(0, 8'h00, 0, 0, 0, 0);

      // Beat without sop in idle, then sop in the middle of a frame.
      cyc(1, 8'hAA, 0, 0, 1, 0);
      cyc(0, 8'h00, 0, 0, 1, 0);
      cyc(1, 8'h11, 1, 0, 0, 0);
      cyc(1, 8'h22, 0, 0, 0, 0);
      cyc(1, 8'h31, 1, 1, 0, 0);
      s_valid = 0;
      @(negedge clk);
      chk("lit restart crc", 32'(d0_crc), 32'h97);
      chk("lit restart beats", 32'(d0_beats), 32'd1);
      chk("lit restart err", 32'(d0_err), 32'd1);
      @(posedge clk); #1;
      cyc(0, 8'h00, 0, 0, 1, 0);

      // Reset aborts a partial frame; reset beats a simultaneous beat.
      cyc(1, 8'h01, 1, 0, 0, 0);
      cyc(1, 8'h02, 0, 0, 0, 0);
      cyc(1, 8'h03, 0, 0, 0, 0);
      cyc(1, 8'h04, 0, 0, 0, 0);
      cyc(1, 8'h05, 0, 1, 1, 1);
      s_valid = 0;
      @(negedge clk);
      chk("lit rst valid", 32'(d0_mv), 32'd0);
      chk("lit rst ready", 32'(d0_rdy), 32'd1);
      @(posedge clk); #1;
      frame_123(1'b0);
      s_valid = 0;
      @(negedge clk);
      chk("lit post-rst crc", 32'(d0_crc), 32'hF4);
      @(posedge clk); #1;
      cyc(0, 8'h00, 0, 0, 1, 0);

      // Random traffic.
      for (int n = 0; n < 1500; n++)
         cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 59) == 0);

      cyc(0, 8'h00, 0, 0, 1, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
